// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register with word-boundary status.
// One bit per clock; out holds the last WIDTH bits received.
module sipo_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     in,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     word_valid,
    output logic                     filled
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] nxt;
    logic             last;

    assign last = (bit_cnt == LAST);

    // Next parallel word: new bit enters at the end chosen by LSB_FIRST.
    always_comb begin
        nxt = out;
        if (LSB_FIRST) begin
            nxt = {in, out[WIDTH-1:1]};
        end else begin
            nxt = {out[WIDTH-2:0], in};
        end
    end

    // Shift every cycle; counter wraps at the word boundary.
    always_ff @(posedge Clk) begin
        if (rst) begin
            out        <= '0;
            bit_cnt    <= '0;
            word_valid <= 1'b0;
            filled     <= 1'b0;
        end else begin
            out        <= nxt;
            bit_cnt    <= last ? '0 : bit_cnt + CW'(1);
            word_valid <= last;
            if (last) begin
                filled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg: three instances share one serial stream
// and are compared against a bit-history model every cycle.
module tb_sipo_shift_reg;

    logic clk;
    logic rst;
    logic in;

    logic [3:0] out0, out1;
    logic [4:0] out2;
    logic [1:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic       wv0, wv1, wv2;
    logic       fl0, fl1, fl2;

    int checks = 0;
    int errors = 0;

    bit   hist[$];
    int   n = 0;
    bit   live = 0;

    sipo_shift_reg #(.WIDTH(4), .LSB_FIRST(1'b0)) u0 (
        .Clk(clk), .rst(rst), .in(in), .out(out0),
        .bit_cnt(cnt0), .word_valid(wv0), .filled(fl0)
    );

    sipo_shift_reg #(.WIDTH(4), .LSB_FIRST(1'b1)) u1 (
        .Clk(clk), .rst(rst), .in(in), .out(out1),
        .bit_cnt(cnt1), .word_valid(wv1), .filled(fl1)
    );

    sipo_shift_reg #(.WIDTH(5), .LSB_FIRST(1'b0)) u2 (
        .Clk(clk), .rst(rst), .in(in), .out(out2),
        .bit_cnt(cnt2), .word_valid(wv2), .filled(fl2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model word: hist[0] is the newest bit, missing history reads as 0.
    function automatic logic [31:0] exp_out(input int w, input bit lsb);
        logic [31:0] e;
        bit          b;
        e = '0;
        for (int i = 0; i < w; i++) begin
            b = (i < hist.size()) ? hist[i] : 1'b0;
            if (lsb) e[w-1-i] = b;
            else     e[i]     = b;
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_cnt(input int w);
        return 32'(n % w);
    endfunction

    function automatic logic [31:0] exp_wv(input int w);
        return 32'((n > 0) && (n % w == 0));
    endfunction

    function automatic logic [31:0] exp_fl(input int w);
        return 32'(n >= w);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            hist.delete();
            live = 1'b1;
        end else begin
            hist.push_front(in);
            if (hist.size() > 32) void'(hist.pop_back());
            n++;
        end
        #1;
        if (live) begin
            chk("u0.out", 32'(out0), exp_out(4, 1'b0));
            chk("u0.bit_cnt", 32'(cnt0), exp_cnt(4));
            chk("u0.word_valid", 32'(wv0), exp_wv(4));
            chk("u0.filled", 32'(fl0), exp_fl(4));
            chk("u1.out", 32'(out1), exp_out(4, 1'b1));
            chk("u1.bit_cnt", 32'(cnt1), exp_cnt(4));
            chk("u1.word_valid", 32'(wv1), exp_wv(4));
            chk("u1.filled", 32'(fl1), exp_fl(4));
            chk("u2.out", 32'(out2), exp_out(5, 1'b0));
            chk("u2.bit_cnt", 32'(cnt2), exp_cnt(5));
            chk("u2.word_valid", 32'(wv2), exp_wv(5));
            chk("u2.filled", 32'(fl2), exp_fl(5));
        end
    end

    task automatic shift(input logic b);
        @(negedge clk);
        rst = 1'b0;
        in  = b;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_edge();
        @(negedge clk);
        rst = 1'b1;
        in  = 1'bx;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] e_out2 [4];
    logic [1:0] e_cnt2 [4];
    logic [3:0] e_out3 [4];
    logic [3:0] e_out4 [4];
    logic       b4     [4];
    int         pulses;
    int         pulse_at;

    initial begin
        e_out2 = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
        e_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd0};
        e_out3 = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
        e_out4 = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        b4     = '{1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        in  = 1'bx;
        @(posedge clk);
        #2;
        chk("lit rst out", 32'(out0), 32'h0);
        chk("lit rst cnt", 32'(cnt0), 32'h0);
        chk("lit rst wv", 32'(wv0), 32'h0);
        chk("lit rst filled", 32'(fl0), 32'h0);

        for (int i = 0; i < 4; i++) begin
            shift(e_out2[3][3-i]);
            chk("lit msb out", 32'(out0), 32'(e_out2[i]));
            chk("lit msb cnt", 32'(cnt0), 32'(e_cnt2[i]));
            chk("lit msb wv", 32'(wv0), 32'(i == 3));
            chk("lit msb filled", 32'(fl0), 32'(i == 3));
        end

        for (int i = 0; i < 4; i++) begin
            shift(1'b0);
            chk("lit flush out", 32'(out0), 32'(e_out3[i]));
            chk("lit flush wv", 32'(wv0), 32'(i == 3));
            chk("lit flush filled", 32'(fl0), 32'h1);
        end

        reset_edge();
        for (int i = 0; i < 4; i++) begin
            shift(b4[i]);
            chk("lit lsb out", 32'(out1), 32'(e_out4[i]));
        end

        reset_edge();
        shift(1'b1);
        shift(1'b1);
        reset_edge();
        chk("lit midrst out", 32'(out0), 32'h0);
        chk("lit midrst cnt", 32'(cnt0), 32'h0);
        chk("lit midrst filled", 32'(fl0), 32'h0);
        for (int i = 0; i < 4; i++) shift(1'b1);
        chk("lit midrst ones", 32'(out0), 32'hf);
        chk("lit midrst wv", 32'(wv0), 32'h1);

        for (int i = 0; i < 3; i++) begin
            reset_edge();
            chk("lit hold rst out", 32'(out2), 32'h0);
            chk("lit hold rst filled", 32'(fl2), 32'h0);
        end

        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 12; i++) begin
            shift(1'($urandom_range(0, 1)));
            if (wv0 === 1'b1) begin
                pulses++;
                pulse_at += i;
            end
        end
        chk("lit stream pulses", 32'(pulses), 32'd3);
        chk("lit stream pulse pos", 32'(pulse_at), 32'd24);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 40) == 0) reset_edge();
            else shift(1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
